// File: rtl/mmio_pkg.sv
// ----------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the MMIO GPIO slave.
// - AXI4-Lite field widths and response encodings
// - GPIO register offsets (low address byte only; upstream decodes the window)
// - FSM state enums and the register-select enum
// - decodeOffset(): low address byte -> register select (unaligned -> SEL_NONE)
// - strbMask():     wstrb -> per-bit byte-lane mask
// ----------------------------------------------------------------------------
package mmio_pkg;

    localparam int AXI_ADDR_W   = 32;
    localparam int AXI_DATA_W   = 32;
    localparam int AXI_STRB_W   = AXI_DATA_W / 8;
    localparam int REG_OFFSET_W = 8;

    localparam logic [REG_OFFSET_W-1:0] OFF_OUT      = 8'h00;
    localparam logic [REG_OFFSET_W-1:0] OFF_IN       = 8'h04;
    localparam logic [REG_OFFSET_W-1:0] OFF_IRQ_EN   = 8'h08;
    localparam logic [REG_OFFSET_W-1:0] OFF_IRQ_STAT = 8'h0C;
    localparam logic [REG_OFFSET_W-1:0] OFF_EDGE_SEL = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    typedef enum logic [2:0] {
        SEL_OUT,
        SEL_IN,
        SEL_IRQ_EN,
        SEL_IRQ_STAT,
        SEL_EDGE_SEL,
        SEL_NONE
    } reg_sel_t;

    // Any offset that is not exactly one of the word addresses (including
    // unaligned ones) falls through to SEL_NONE.
    function automatic reg_sel_t decodeOffset(input logic [REG_OFFSET_W-1:0] offset);
        reg_sel_t sel;
        sel = SEL_NONE;
        case (offset)
            OFF_OUT:      sel = SEL_OUT;
            OFF_IN:       sel = SEL_IN;
            OFF_IRQ_EN:   sel = SEL_IRQ_EN;
            OFF_IRQ_STAT: sel = SEL_IRQ_STAT;
            OFF_EDGE_SEL: sel = SEL_EDGE_SEL;
            default:      sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [AXI_DATA_W-1:0] strbMask(input logic [AXI_STRB_W-1:0] strb);
        logic [AXI_DATA_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < AXI_STRB_W; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mmio_gpio_if.sv
// ----------------------------------------------------------------------------
// mmio_gpio_if
// AXI4-Lite bundle between the upstream mmio controller (master) and the GPIO
// block (slave). Channels: aw, w, b, ar, r with standard signal directions.
// ----------------------------------------------------------------------------
interface mmio_gpio_if;
    import mmio_pkg::*;

    logic [AXI_ADDR_W-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [AXI_ADDR_W-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// ----------------------------------------------------------------------------
// gpio_sync_edge
// Multi-flop synchronizer for a vector of asynchronous pins, plus (when the
// GPIO_IRQ_EN macro is defined) a one-cycle rising/falling edge detector on
// the synchronized value.
// Ports:
//   aclk, arst_n : clock, async active-low reset
//   i_pins       : asynchronous pin vector
//   o_sync       : pins after STAGES flops
//   o_rise/o_fall: single-cycle edge pulses (tied 0 without GPIO_IRQ_EN)
// ----------------------------------------------------------------------------
module gpio_sync_edge #(
    parameter int WIDTH  = 9,
    parameter int STAGES = 2
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // Plain shift chain; stage 0 is the only flop that can go metastable.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_pins;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[STAGES-1];

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] r_prev;

    // Remember last cycle's synchronized value so edges can be spotted.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= o_sync;
        end
    end

    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;
`else
    assign o_rise = '0;
    assign o_fall = '0;
`endif

endmodule

// File: rtl/mmio_gpio.sv
// ----------------------------------------------------------------------------
// mmio_gpio
// AXI4-Lite GPIO slave: OUT (RW), IN (RO, synchronized), IRQ_EN (RW),
// IRQ_STAT (W1C), EDGE_SEL (RW, 1=rising). Only addr[7:0] is decoded.
// Optional feature macro: GPIO_IRQ_EN (edge interrupts). Without it the IRQ
// registers read 0, ignore writes, and irq is tied low.
// Ports:
//   aclk, arst_n : clock, async active-low reset
//   S_AXI        : AXI4-Lite slave (mmio_gpio_if.slave)
//   in_ports     : asynchronous input pins
//   out_ports    : OUT register
//   irq          : registered level interrupt
// ----------------------------------------------------------------------------
module mmio_gpio
    import mmio_pkg::*;
#(
    parameter int NUM_PORTS   = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 aclk,
    input  logic                 arst_n,
    mmio_gpio_if.slave           S_AXI,
    input  logic [NUM_PORTS-1:0] in_ports,
    output logic [NUM_PORTS-1:0] out_ports,
    output logic                 irq
);

    wr_state_t r_wrState, w_wrNext;
    rd_state_t r_rdState, w_rdNext;

    logic                    r_awReady, r_wReady, r_arReady;
    logic                    r_awCap, r_wCap;
    logic [REG_OFFSET_W-1:0] r_awAddr;
    logic                    r_awProtNs;
    logic [AXI_DATA_W-1:0]   r_wData;
    logic [AXI_STRB_W-1:0]   r_wStrb;
    logic [1:0]              r_bresp;
    logic [AXI_DATA_W-1:0]   r_rdata;
    logic [1:0]              r_rresp;
    logic [NUM_PORTS-1:0]    r_outReg;

    logic                    w_awFire, w_wFire, w_arFire;
    logic                    w_awCapNext, w_wCapNext, w_wrCommit;
    logic [REG_OFFSET_W-1:0] w_wrAddr;
    logic                    w_wrProtNs;
    logic [AXI_DATA_W-1:0]   w_wrData;
    logic [AXI_STRB_W-1:0]   w_wrStrb;
    reg_sel_t                w_wrSel, w_rdSel;
    logic                    w_wrErr;
    logic [AXI_DATA_W-1:0]   w_mask;
    logic [NUM_PORTS-1:0]    w_maskN, w_dataN;
    logic [AXI_DATA_W-1:0]   w_rdValue;
    logic [1:0]              w_rdResp;
    logic [NUM_PORTS-1:0]    w_syncIn, w_rise, w_fall;
    logic [NUM_PORTS-1:0]    w_irqEn, w_irqStat, w_edgeSel;
    logic                    w_unusedBits;

    gpio_sync_edge #(
        .WIDTH  (NUM_PORTS),
        .STAGES (SYNC_STAGES)
    ) u_syncEdge (
        .aclk   (aclk),
        .arst_n (arst_n),
        .i_pins (in_ports),
        .o_sync (w_syncIn),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Write channel: AW and W may arrive in either order or together. A
    // channel handshaking this cycle is used directly so a same-cycle pair
    // commits without an extra stall.
    always_comb begin
        w_awFire    = S_AXI.awvalid && r_awReady;
        w_wFire     = S_AXI.wvalid && r_wReady;
        w_awCapNext = r_awCap | w_awFire;
        w_wCapNext  = r_wCap | w_wFire;
        w_wrAddr    = w_awFire ? S_AXI.awaddr[REG_OFFSET_W-1:0] : r_awAddr;
        w_wrProtNs  = w_awFire ? S_AXI.awprot[1] : r_awProtNs;
        w_wrData    = w_wFire ? S_AXI.wdata : r_wData;
        w_wrStrb    = w_wFire ? S_AXI.wstrb : r_wStrb;
        w_wrNext    = r_wrState;
        w_wrCommit  = 1'b0;
        case (r_wrState)
            WR_IDLE: begin
                if (w_awCapNext && w_wCapNext) begin
                    w_wrNext   = WR_RESP;
                    w_wrCommit = 1'b1;
                end
            end
            WR_RESP: begin
                if (S_AXI.bready) begin
                    w_wrNext = WR_IDLE;
                end
            end
            default: w_wrNext = WR_IDLE;
        endcase
    end

    // IN is read-only, so writing it is reported as an error like a hole.
    always_comb begin
        w_wrSel = decodeOffset(w_wrAddr);
        w_wrErr = w_wrProtNs || (w_wrSel == SEL_NONE) || (w_wrSel == SEL_IN);
        w_mask  = strbMask(w_wrStrb);
        w_maskN = w_mask[NUM_PORTS-1:0];
        w_dataN = w_wrData[NUM_PORTS-1:0] & w_maskN;
    end

    // Ready flags are registered from the next state so they are low in reset
    // and fall on the same edge that captures their channel.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_wrState  <= WR_IDLE;
            r_awReady  <= 1'b0;
            r_wReady   <= 1'b0;
            r_awCap    <= 1'b0;
            r_wCap     <= 1'b0;
            r_awAddr   <= '0;
            r_awProtNs <= 1'b0;
            r_wData    <= '0;
            r_wStrb    <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wrState <= w_wrNext;
            r_awReady <= (w_wrNext == WR_IDLE) && !w_awCapNext;
            r_wReady  <= (w_wrNext == WR_IDLE) && !w_wCapNext;
            r_awCap   <= w_wrCommit ? 1'b0 : w_awCapNext;
            r_wCap    <= w_wrCommit ? 1'b0 : w_wCapNext;
            if (w_awFire) begin
                r_awAddr   <= S_AXI.awaddr[REG_OFFSET_W-1:0];
                r_awProtNs <= S_AXI.awprot[1];
            end
            if (w_wFire) begin
                r_wData <= S_AXI.wdata;
                r_wStrb <= S_AXI.wstrb;
            end
            if (w_wrCommit) begin
                r_bresp <= w_wrErr ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // OUT updates on the commit edge, so out_ports changes with bvalid.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_outReg <= '0;
        end else if (w_wrCommit && !w_wrErr && (w_wrSel == SEL_OUT)) begin
            r_outReg <= (r_outReg & ~w_maskN) | w_dataN;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [NUM_PORTS-1:0] r_irqEn, r_irqStat, r_edgeSel;
    logic [NUM_PORTS-1:0] w_statClr, w_edges;
    logic                 r_irq;

    assign w_edges   = (w_rise & r_edgeSel) | (w_fall & ~r_edgeSel);
    assign w_statClr = (w_wrCommit && !w_wrErr && (w_wrSel == SEL_IRQ_STAT)) ? w_dataN : '0;

    // A new edge wins over a simultaneous W1C because it is OR-ed in last.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_irqEn   <= '0;
            r_irqStat <= '0;
            r_edgeSel <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wrCommit && !w_wrErr && (w_wrSel == SEL_IRQ_EN)) begin
                r_irqEn <= (r_irqEn & ~w_maskN) | w_dataN;
            end
            if (w_wrCommit && !w_wrErr && (w_wrSel == SEL_EDGE_SEL)) begin
                r_edgeSel <= (r_edgeSel & ~w_maskN) | w_dataN;
            end
            r_irqStat <= (r_irqStat & ~w_statClr) | w_edges;
            r_irq     <= |(r_irqStat & r_irqEn);
        end
    end

    assign w_irqEn   = r_irqEn;
    assign w_irqStat = r_irqStat;
    assign w_edgeSel = r_edgeSel;
    assign irq       = r_irq;
`else
    logic w_unusedEdges;
    assign w_unusedEdges = ^{w_rise, w_fall};
    assign w_irqEn   = '0;
    assign w_irqStat = '0;
    assign w_edgeSel = '0;
    assign irq       = 1'b0;
`endif

    // Read path: data and response are latched at the AR handshake and held
    // unchanged until rready.
    always_comb begin
        w_arFire  = S_AXI.arvalid && r_arReady;
        w_rdSel   = decodeOffset(S_AXI.araddr[REG_OFFSET_W-1:0]);
        w_rdValue = '0;
        w_rdResp  = RESP_OKAY;
        case (w_rdSel)
            SEL_OUT:      w_rdValue = AXI_DATA_W'(r_outReg);
            SEL_IN:       w_rdValue = AXI_DATA_W'(w_syncIn);
            SEL_IRQ_EN:   w_rdValue = AXI_DATA_W'(w_irqEn);
            SEL_IRQ_STAT: w_rdValue = AXI_DATA_W'(w_irqStat);
            SEL_EDGE_SEL: w_rdValue = AXI_DATA_W'(w_edgeSel);
            default:      w_rdResp  = RESP_SLVERR;
        endcase
        w_rdNext = r_rdState;
        case (r_rdState)
            RD_IDLE: if (w_arFire) w_rdNext = RD_DATA;
            RD_DATA: if (S_AXI.rready) w_rdNext = RD_IDLE;
            default: w_rdNext = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_rdState <= RD_IDLE;
            r_arReady <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rdState <= w_rdNext;
            r_arReady <= (w_rdNext == RD_IDLE);
            if (w_arFire) begin
                r_rdata <= w_rdValue;
                r_rresp <= w_rdResp;
            end
        end
    end

    assign S_AXI.awready = r_awReady;
    assign S_AXI.wready  = r_wReady;
    assign S_AXI.bvalid  = (r_wrState == WR_RESP);
    assign S_AXI.bresp   = r_bresp;
    assign S_AXI.arready = r_arReady;
    assign S_AXI.rvalid  = (r_rdState == RD_DATA);
    assign S_AXI.rdata   = r_rdata;
    assign S_AXI.rresp   = r_rresp;
    assign out_ports     = r_outReg;

    assign w_unusedBits = ^{S_AXI.awaddr[AXI_ADDR_W-1:REG_OFFSET_W], S_AXI.awprot[2], S_AXI.awprot[0],
                            S_AXI.araddr[AXI_ADDR_W-1:REG_OFFSET_W], S_AXI.arprot, w_wrData, w_mask};

endmodule

// File: tb/tb_mmio_gpio.sv
// ----------------------------------------------------------------------------
// tb_mmio_gpio
// Directed self-checking bench for mmio_gpio (NUM_PORTS=9, SYNC_STAGES=2).
// The IRQ scenario follows the GPIO_IRQ_EN macro of the build.
// ----------------------------------------------------------------------------
module tb_mmio_gpio;
    import mmio_pkg::*;

    logic       aclk;
    logic       arst_n;
    logic [8:0] inPorts;
    logic [8:0] outPorts;
    logic       irq;

    int testsRun    = 0;
    int testsFailed = 0;

    mmio_gpio_if bus();

    mmio_gpio #(
        .NUM_PORTS   (9),
        .SYNC_STAGES (2)
    ) dut (
        .aclk      (aclk),
        .arst_n    (arst_n),
        .S_AXI     (bus),
        .in_ports  (inPorts),
        .out_ports (outPorts),
        .irq       (irq)
    );

    // 10 ns clock.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Issue one write; AW and W start awDelay/wDelay cycles after entry.
    // bLat counts edges between the final channel capture and bvalid.
    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [2:0] prot, input int awDelay, input int wDelay,
                           output logic [1:0] resp, output int bLat, output bit ok);
        bit awDone, wDone, awFire, wFire;
        int cyc;
        awDone = 0; wDone = 0; cyc = 0; ok = 1; resp = 2'b11; bLat = -1;
        bus.awaddr = addr; bus.awprot = prot; bus.wdata = data; bus.wstrb = strb;
        while (!(awDone && wDone) && cyc < 50) begin
            bus.awvalid = !awDone && (cyc >= awDelay);
            bus.wvalid  = !wDone && (cyc >= wDelay);
            awFire = bus.awvalid && bus.awready;
            wFire  = bus.wvalid && bus.wready;
            @(posedge aclk); #1; cyc++;
            if (awFire) awDone = 1;
            if (wFire)  wDone = 1;
        end
        bus.awvalid = 0; bus.wvalid = 0;
        if (!(awDone && wDone)) begin
            ok = 0;
            return;
        end
        cyc = 0;
        while (!bus.bvalid && cyc < 20) begin
            @(posedge aclk); #1; cyc++;
        end
        if (!bus.bvalid) begin
            ok = 0;
            return;
        end
        bLat = cyc;
        resp = bus.bresp;
        bus.bready = 1;
        @(posedge aclk); #1;
        bus.bready = 0;
    endtask

    // Issue one read; rLat counts edges between the AR handshake and rvalid.
    task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int rLat, output bit ok);
        bit arFire;
        int cyc;
        ok = 1; data = '1; resp = 2'b11; rLat = -1; cyc = 0; arFire = 0;
        bus.araddr = addr; bus.arprot = 3'b000; bus.arvalid = 1;
        while (!arFire && cyc < 50) begin
            arFire = bus.arready;
            @(posedge aclk); #1; cyc++;
        end
        bus.arvalid = 0;
        if (!arFire) begin
            ok = 0;
            return;
        end
        cyc = 0;
        while (!bus.rvalid && cyc < 20) begin
            @(posedge aclk); #1; cyc++;
        end
        if (!bus.rvalid) begin
            ok = 0;
            return;
        end
        rLat = cyc;
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1;
        @(posedge aclk); #1;
        bus.rready = 0;
    endtask

    // Everything must be quiet while reset is held, and OUT must read 0 after.
    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        arst_n = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        testsRun++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready: got %b expected 000", {bus.awready, bus.wready, bus.arready});
        end
        testsRun++;
        if ({bus.bvalid, bus.rvalid, irq} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid_irq: got %b expected 000", {bus.bvalid, bus.rvalid, irq});
        end
        testsRun++;
        if (outPorts !== 9'h000) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_ports: got %h expected 000", outPorts);
        end
        @(negedge aclk);
        arst_n = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        doRead(32'h4600_0100, d, r, lat, ok);
        testsRun++;
        if (!ok || d !== 32'h0 || r !== RESP_OKAY) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_read: got ok=%0d data=%h resp=%b expected ok=1 data=0 resp=00", ok, d, r);
        end
    endtask

    // AW first, W one cycle later; bvalid right after the W capture.
    task automatic test_write_out();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        doWrite(32'h4600_0100, 32'h0000_01A5, 4'hF, 3'b000, 0, 1, r, lat, ok);
        testsRun++;
        if (!ok || r !== RESP_OKAY || lat !== 0) begin
            testsFailed++;
            $display("[TB] FAIL write_out_resp: got ok=%0d resp=%b lat=%0d expected ok=1 resp=00 lat=0", ok, r, lat);
        end
        testsRun++;
        if (outPorts !== 9'h1A5) begin
            testsFailed++;
            $display("[TB] FAIL write_out_pins: got %h expected 1a5", outPorts);
        end
        doRead(32'h4600_0100, d, r, lat, ok);
        testsRun++;
        if (!ok || d !== 32'h1A5 || r !== RESP_OKAY || lat !== 0) begin
            testsFailed++;
            $display("[TB] FAIL write_out_readback: got data=%h resp=%b lat=%0d expected 1a5 00 0", d, r, lat);
        end
    endtask

    // Byte strobes with W before AW, then a full write of all ones.
    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        doWrite(32'h4600_0100, 32'hFFFF_FF3C, 4'b0001, 3'b000, 2, 0, r, lat, ok);
        testsRun++;
        if (!ok || r !== RESP_OKAY || lat !== 0 || outPorts !== 9'h13C) begin
            testsFailed++;
            $display("[TB] FAIL strobe_lane0: got ok=%0d resp=%b lat=%0d out=%h expected 1 00 0 13c", ok, r, lat, outPorts);
        end
        doWrite(32'h4600_0100, 32'h0000_0000, 4'b0010, 3'b000, 0, 0, r, lat, ok);
        testsRun++;
        if (!ok || r !== RESP_OKAY || outPorts !== 9'h03C) begin
            testsFailed++;
            $display("[TB] FAIL strobe_lane1: got ok=%0d resp=%b out=%h expected 1 00 03c", ok, r, outPorts);
        end
        doWrite(32'h4600_0100, 32'hFFFF_FFFF, 4'hF, 3'b000, 0, 0, r, lat, ok);
        doRead(32'h4600_0100, d, r, lat, ok);
        testsRun++;
        if (!ok || d !== 32'h0000_01FF || outPorts !== 9'h1FF) begin
            testsFailed++;
            $display("[TB] FAIL strobe_upper_bits: got data=%h out=%h expected 000001ff 1ff", d, outPorts);
        end
    endtask

    // Held pins show up in IN once they have crossed the synchronizer.
    task automatic test_read_in();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        inPorts = 9'h0F3;
        repeat (5) @(posedge aclk);
        #1;
        doRead(32'h4600_0104, d, r, lat, ok);
        testsRun++;
        if (!ok || d !== 32'h0F3 || r !== RESP_OKAY || lat !== 0) begin
            testsFailed++;
            $display("[TB] FAIL read_in: got ok=%0d data=%h resp=%b lat=%0d expected 1 0f3 00 0", ok, d, r, lat);
        end
    endtask

    // Holes, unaligned, read-only and non-secure accesses all get SLVERR.
    task automatic test_errors();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        doRead(32'h4600_0114, d, r, lat, ok);
        testsRun++;
        if (!ok || d !== 32'h0 || r !== RESP_SLVERR) begin
            testsFailed++;
            $display("[TB] FAIL err_read_hole: got data=%h resp=%b expected 0 10", d, r);
        end
        doRead(32'h4600_0102, d, r, lat, ok);
        testsRun++;
        if (!ok || d !== 32'h0 || r !== RESP_SLVERR) begin
            testsFailed++;
            $display("[TB] FAIL err_read_unaligned: got data=%h resp=%b expected 0 10", d, r);
        end
        doWrite(32'h4600_0104, 32'h0000_0000, 4'hF, 3'b000, 0, 0, r, lat, ok);
        testsRun++;
        if (!ok || r !== RESP_SLVERR || outPorts !== 9'h1FF) begin
            testsFailed++;
            $display("[TB] FAIL err_write_in: got resp=%b out=%h expected 10 1ff", r, outPorts);
        end
        doWrite(32'h4600_0100, 32'h0000_0000, 4'hF, 3'b010, 0, 0, r, lat, ok);
        testsRun++;
        if (!ok || r !== RESP_SLVERR || outPorts !== 9'h1FF) begin
            testsFailed++;
            $display("[TB] FAIL err_write_nonsecure: got resp=%b out=%h expected 10 1ff", r, outPorts);
        end
        doWrite(32'h4600_0120, 32'h0000_0000, 4'hF, 3'b000, 0, 0, r, lat, ok);
        testsRun++;
        if (!ok || r !== RESP_SLVERR || outPorts !== 9'h1FF) begin
            testsFailed++;
            $display("[TB] FAIL err_write_hole: got resp=%b out=%h expected 10 1ff", r, outPorts);
        end
    endtask

`ifdef GPIO_IRQ_EN
    // Rising edge on pin0 raises irq; W1C of bit0 drops it again.
    task automatic test_irq();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        inPorts = 9'h000;
        repeat (6) @(posedge aclk);
        #1;
        doWrite(32'h4600_0110, 32'h0000_0001, 4'hF, 3'b000, 0, 0, r, lat, ok);
        doWrite(32'h4600_0108, 32'h0000_0001, 4'hF, 3'b000, 0, 0, r, lat, ok);
        doWrite(32'h4600_010C, 32'h0000_01FF, 4'hF, 3'b000, 0, 0, r, lat, ok);
        repeat (3) @(posedge aclk);
        #1;
        testsRun++;
        if (irq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL irq_idle: got %b expected 0", irq);
        end
        inPorts = 9'h001;
        repeat (8) @(posedge aclk);
        #1;
        testsRun++;
        if (irq !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL irq_rise: got %b expected 1", irq);
        end
        doRead(32'h4600_010C, d, r, lat, ok);
        testsRun++;
        if (!ok || d !== 32'h1 || r !== RESP_OKAY) begin
            testsFailed++;
            $display("[TB] FAIL irq_stat: got data=%h resp=%b expected 1 00", d, r);
        end
        doWrite(32'h4600_010C, 32'h0000_0001, 4'hF, 3'b000, 0, 0, r, lat, ok);
        repeat (3) @(posedge aclk);
        #1;
        testsRun++;
        if (irq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL irq_w1c: got %b expected 0", irq);
        end
    endtask
`else
    // Without the interrupt feature the IRQ registers are inert zeros.
    task automatic test_irq();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        doWrite(32'h4600_0108, 32'h0000_01FF, 4'hF, 3'b000, 0, 0, r, lat, ok);
        testsRun++;
        if (!ok || r !== RESP_OKAY) begin
            testsFailed++;
            $display("[TB] FAIL irq_off_write: got ok=%0d resp=%b expected 1 00", ok, r);
        end
        doRead(32'h4600_0108, d, r, lat, ok);
        testsRun++;
        if (!ok || d !== 32'h0 || r !== RESP_OKAY) begin
            testsFailed++;
            $display("[TB] FAIL irq_off_en_read: got data=%h resp=%b expected 0 00", d, r);
        end
        doRead(32'h4600_0110, d, r, lat, ok);
        testsRun++;
        if (!ok || d !== 32'h0 || r !== RESP_OKAY || irq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL irq_off_edge_read: got data=%h resp=%b irq=%b expected 0 00 0", d, r, irq);
        end
    endtask
`endif

    // rready held low: response must not move for five cycles.
    task automatic test_rready_stall();
        int cyc; bit arFire; bit stable;
        cyc = 0; arFire = 0; stable = 1;
        bus.araddr = 32'h4600_0100; bus.arprot = 3'b000; bus.arvalid = 1;
        while (!arFire && cyc < 50) begin
            arFire = bus.arready;
            @(posedge aclk); #1; cyc++;
        end
        bus.arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1FF || bus.rresp !== RESP_OKAY) stable = 0;
            @(posedge aclk); #1;
        end
        testsRun++;
        if (!arFire || !stable || bus.rvalid !== 1'b1 || bus.rdata !== 32'h1FF) begin
            testsFailed++;
            $display("[TB] FAIL rready_stall: got ar=%0d stable=%0d rvalid=%b rdata=%h expected 1 1 1 1ff",
                     arFire, stable, bus.rvalid, bus.rdata);
        end
        bus.rready = 1;
        @(posedge aclk); #1;
        bus.rready = 0;
    endtask

    // A read and a write in flight together must not disturb each other.
    task automatic test_back_to_back();
        logic [31:0] rd; logic [1:0] rr, wr; int rl, wl; bit rok, wok;
        fork
            doWrite(32'h4600_0100, 32'h0000_0055, 4'hF, 3'b000, 0, 0, wr, wl, wok);
            doRead(32'h4600_0104, rd, rr, rl, rok);
        join
        testsRun++;
        if (!wok || wr !== RESP_OKAY || wl !== 0 || outPorts !== 9'h055) begin
            testsFailed++;
            $display("[TB] FAIL b2b_write: got ok=%0d resp=%b lat=%0d out=%h expected 1 00 0 055", wok, wr, wl, outPorts);
        end
        testsRun++;
        if (!rok || rr !== RESP_OKAY || rl !== 0 || rd !== 32'h0F3) begin
            testsFailed++;
            $display("[TB] FAIL b2b_read: got ok=%0d resp=%b lat=%0d data=%h expected 1 00 0 0f3", rok, rr, rl, rd);
        end
    endtask

    // Reset between AW and W: the half write is forgotten, no response ever.
    task automatic test_reset_mid_write();
        int cyc; bit fire; bit sawB;
        inPorts = 9'h0F3;
        cyc = 0; fire = 0; sawB = 0;
        bus.awaddr = 32'h4600_0100; bus.awprot = 3'b000; bus.awvalid = 1;
        while (!fire && cyc < 50) begin
            fire = bus.awready;
            @(posedge aclk); #1; cyc++;
        end
        bus.awvalid = 0;
        arst_n = 1'b0;
        #2;
        @(negedge aclk);
        arst_n = 1'b1;
        bus.wdata = 32'h0000_01FF; bus.wstrb = 4'hF; bus.wvalid = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge aclk); #1;
            if (bus.wready === 1'b0 && i > 1) bus.wvalid = 0;
            if (bus.bvalid !== 1'b0) sawB = 1;
        end
        bus.wvalid = 0;
        testsRun++;
        if (!fire || sawB) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_write_bvalid: got aw=%0d bvalid_seen=%0d expected 1 0", fire, sawB);
        end
        testsRun++;
        if (outPorts !== 9'h000) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_write_out: got %h expected 000", outPorts);
        end
    endtask

    // Test sequence.
    initial begin
        arst_n      = 1'b1;
        inPorts     = '0;
        bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 0;
        bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 0;
        bus.bready  = 0;
        bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 0;
        bus.rready  = 0;
        #2;
        test_reset();
        test_write_out();
        test_strobe();
        test_read_in();
        test_errors();
        test_rready_stall();
        test_back_to_back();
        test_irq();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mmio_gpio.md
MMIO_GPIO -- requirements
Module: mmio_gpio

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 9, GPIO pin count (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (>=2).
REQ-003 SHALL have port aclk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have AXI4-Lite slave ports S_AXI_aw{addr[31:0],prot[2:0],valid,ready}, S_AXI_w{data[31:0],strb[3:0],valid,ready}, S_AXI_b{resp[1:0],valid,ready}, S_AXI_ar{addr[31:0],prot[2:0],valid,ready}, S_AXI_r{data[31:0],resp[1:0],valid,ready}, with standard directions; the upstream mmio controller drives them for window 0x4600_01XX.
REQ-006 SHALL have port in_ports  input  NUM_PORTS  asynchronous external pins.
REQ-007 SHALL have port out_ports  output  NUM_PORTS  registered output pins.
REQ-008 SHALL have port irq  output  1  level interrupt (only with GPIO_IRQ_EN).

Function
REQ-009 SHALL decode only awaddr/araddr[7:0]; bits [31:8] ignored (upstream decodes).
REQ-010 SHALL implement the register map: 0x00 OUT (RW), 0x04 IN (RO, synchronized pins), 0x08 IRQ_EN (RW), 0x0C IRQ_STAT (W1C), 0x10 EDGE_SEL (RW, 1=rising, 0=falling); bits above NUM_PORTS read 0.
REQ-011 SHALL use a write FSM IDLE -> (AW and W captured, either order or same cycle) -> RESP -> IDLE on bready; awready/wready SHALL be high in IDLE only until their channel has been captured.
REQ-012 SHALL apply a write on entering RESP, honouring wstrb per byte; bvalid SHALL assert the cycle after the second capture and hold until bready.
REQ-013 SHALL use a read FSM IDLE -> DATA; arready high in IDLE; rvalid, rdata, rresp SHALL assert exactly one cycle after the AR handshake and hold stable until rready.
REQ-014 SHALL respond SLVERR (2'b10) with rdata 0 to unmapped or unaligned offsets, and OKAY (2'b00) otherwise; writes to IN or to unmapped offsets SHALL have no effect.
REQ-015 SHALL respond SLVERR to any write whose awprot[1] is 1 (non-secure); the write SHALL be dropped.
REQ-016 SHALL allow one outstanding read and one outstanding write concurrently and independently.
REQ-017 SHALL drive out_ports directly from the OUT register (zero added latency after write commit).
REQ-018 SHALL pass in_ports through SYNC_STAGES flops; IN reads see pins SYNC_STAGES+1 cycles late.

Reset
REQ-019 SHALL, while arst_n is low, clear OUT, IRQ_EN, IRQ_STAT, EDGE_SEL, the synchronizers, both FSMs (IDLE), and drive all valid/ready/irq/out_ports low.
REQ-020 SHALL abandon any in-flight transaction on reset, with no response issued afterwards.

Configuration
REQ-021 SHALL, with GPIO_IRQ_EN defined, latch a selected edge of each synchronized pin into IRQ_STAT and drive irq = |(IRQ_STAT & IRQ_EN), registered.
REQ-022 SHALL, if an edge and a W1C to the same bit coincide, keep the bit set.
REQ-023 SHALL, without GPIO_IRQ_EN, omit the edge logic, tie irq to 0, and read IRQ_EN/IRQ_STAT/EDGE_SEL as 0 with OKAY and ignore writes to them.

Structure
REQ-024 SHALL take register offsets, field widths, and AXI resp encodings from shared package mmio_pkg.
REQ-025 SHALL place the input synchronizer plus edge detector in the sub-module gpio_sync_edge, one instance per pin vector.

Verification
REQ-026 SHALL cover: AW then W one cycle later, addr 0x4600_0100, wdata 0x1A5, strb 0xF -> bvalid at cycle +1 after W, bresp 00, out_ports = 9'h1A5.
REQ-027 SHALL cover: in_ports = 9'h0F3 held, then read 0x04 -> rvalid one cycle after AR, rdata 0x0F3, rresp 00.
REQ-028 SHALL cover: read 0x4600_0114 and write to 0x4600_0104 -> SLVERR, rdata 0, OUT unchanged.
REQ-029 SHALL cover (GPIO_IRQ_EN): EDGE_SEL=0x001, IRQ_EN=0x001, pin0 0->1 -> IRQ_STAT bit0 set, irq high; W1C 0x001 -> irq low.
REQ-030 SHALL cover: rready held low for 5 cycles -> rdata and rresp stable; arst_n pulsed mid-write -> no bvalid, out_ports 0.
